// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM command-bus tools:
//   sdram_cmd_t  : decoded SDRAM command
//   mon_err_t    : error code reported by sdram_init_monitor (matches err_code)
//   mon_state_t  : sdram_init_monitor FSM states
//   MR_*         : mode-register field positions
//   mr_fields_ok : legality of the CAS-latency / burst-length fields
// -----------------------------------------------------------------------------
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_READ,
    CMD_WRITE,
    CMD_BST,
    CMD_PRE,
    CMD_REF,
    CMD_LMR
  } sdram_cmd_t;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_EARLY  = 3'd1,
    ERR_ORDER  = 3'd2,
    ERR_TIMING = 3'd3,
    ERR_CKE    = 3'd4,
    ERR_MODE   = 3'd5
  } mon_err_t;

  // ST_LMR is kept so the encoding lists every phase of the power-up
  // sequence; LOAD MODE is accepted directly from ST_REF into ST_MRD.
  typedef enum logic [2:0] {
    ST_PWR,
    ST_PRE,
    ST_REF,
    ST_LMR,
    ST_MRD,
    ST_DONE,
    ST_ERR
  } mon_state_t;

  // Mode register layout (SDR SDRAM)
  localparam int MR_BL_LSB         = 0;
  localparam int MR_BL_MSB         = 2;
  localparam int MR_CL_LSB         = 4;
  localparam int MR_CL_MSB         = 6;
  localparam int MR_RSVD_LSB       = 10;
  // addr bit that selects "all banks" on PRECHARGE
  localparam int PRECHARGE_ALL_BIT = 10;

  // CAS latency must be 2 or 3; burst length 1/2/4/8 (0..3) or full page (7).
  function automatic logic mr_fields_ok(input logic [2:0] cl, input logic [2:0] bl);
    return ((cl == 3'd2) || (cl == 3'd3)) && ((bl <= 3'd3) || (bl == 3'd7));
  endfunction

endpackage

// File: rtl/sdram_cmd_decode.sv
// -----------------------------------------------------------------------------
// sdram_cmd_decode
// Purely combinational SDRAM command decoder. With cs_n low the command is
// taken from {ras_n, cas_n, we_n}; a deselected device sees NOP.
// Ports:
//   cs_n, ras_n, cas_n, we_n : SDRAM control pins (active-low)
//   cmd                      : decoded command (sdram_cmd_t)
// -----------------------------------------------------------------------------
module sdram_cmd_decode
  import sdram_pkg::*;
(
  input  logic       cs_n,
  input  logic       ras_n,
  input  logic       cas_n,
  input  logic       we_n,
  output sdram_cmd_t cmd
);

  always_comb begin
    cmd = CMD_NOP;
    if (!cs_n) begin
      case ({ras_n, cas_n, we_n})
        3'b111:  cmd = CMD_NOP;
        3'b011:  cmd = CMD_ACT;
        3'b101:  cmd = CMD_READ;
        3'b100:  cmd = CMD_WRITE;
        3'b110:  cmd = CMD_BST;
        3'b010:  cmd = CMD_PRE;
        3'b001:  cmd = CMD_REF;
        3'b000:  cmd = CMD_LMR;
        default: cmd = CMD_NOP;
      endcase
    end
  end

endmodule

// File: rtl/sdram_init_monitor.sv
// -----------------------------------------------------------------------------
// sdram_init_monitor
// Passive checker for the SDRAM power-up sequence:
//   power-up wait -> PRECHARGE ALL -> REF_COUNT x AUTO REFRESH -> LOAD MODE
// Reports the first ordering / timing / CKE violation, latches the programmed
// mode register and raises init_done once the sequence completed legally.
//
// Optional build macro SDRAM_MON_MODE_CHECK_EN: when defined, the LOAD MODE
// value is checked (CL 2/3, BL 0..3 or 7, reserved bits zero) and an illegal
// value is reported as error code 5.
//
// Ports:
//   sclk, srst          : clock, synchronous active-high reset
//   cke, cs_n, ras_n,
//   cas_n, we_n, ba,
//   addr                : SDRAM command bus, sampled on rising sclk
//   init_done           : sequence completed legally (sticky)
//   init_err            : violation detected (sticky)
//   err_code            : first error (0 none,1 EARLY,2 ORDER,3 TIMING,4 CKE,5 MODE)
//   mode_reg            : addr value captured at LOAD MODE
//   ref_seen            : auto-refreshes counted, saturating at 15
// -----------------------------------------------------------------------------
module sdram_init_monitor
  import sdram_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int BA_W      = 2,
  parameter int T_POWERUP = 10000,
  parameter int T_RP      = 3,
  parameter int T_RFC     = 7,
  parameter int T_MRD     = 2,
  parameter int REF_COUNT = 2
) (
  input  logic              sclk,
  input  logic              srst,
  input  logic              cke,
  input  logic              cs_n,
  input  logic              ras_n,
  input  logic              cas_n,
  input  logic              we_n,
  input  logic [BA_W-1:0]   ba,
  input  logic [ADDR_W-1:0] addr,
  output logic              init_done,
  output logic              init_err,
  output logic [2:0]        err_code,
  output logic [ADDR_W-1:0] mode_reg,
  output logic [3:0]        ref_seen
);

  // One gap timer is shared by all phases, sized for the longest gap.
  localparam int TMR_MAX = (T_RP > T_RFC) ? ((T_RP > T_MRD) ? T_RP : T_MRD)
                                          : ((T_RFC > T_MRD) ? T_RFC : T_MRD);
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam int PWR_W   = $clog2(T_POWERUP + 1);

  localparam logic [TW-1:0]    TMR_ONE  = TW'(1);
  localparam logic [TW-1:0]    TMR_SAT  = {TW{1'b1}};
  localparam logic [TW-1:0]    T_RP_C   = TW'(T_RP);
  localparam logic [TW-1:0]    T_RFC_C  = TW'(T_RFC);
  localparam logic [TW-1:0]    T_MRD_C  = TW'(T_MRD);
  localparam logic [PWR_W-1:0] PWR_DONE = PWR_W'(T_POWERUP);
  localparam logic [3:0]       REF_REQ  = 4'(REF_COUNT);

  sdram_cmd_t cmd;

  sdram_cmd_decode u_cmd_decode (
    .cs_n  (cs_n),
    .ras_n (ras_n),
    .cas_n (cas_n),
    .we_n  (we_n),
    .cmd   (cmd)
  );

  mon_state_t        state_q, state_d;
  logic [PWR_W-1:0]  pwr_cnt_q, pwr_cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              init_done_q, init_done_d;
  logic              init_err_q, init_err_d;
  mon_err_t          err_code_q, err_code_d;
  logic [ADDR_W-1:0] mode_reg_q, mode_reg_d;
  logic [3:0]        ref_seen_q, ref_seen_d;

  logic              is_nop;
  logic [TW-1:0]     timer_inc;
  logic [3:0]        ref_inc;
  logic              mr_valid;
  logic              lmr_accept;
  mon_err_t          raise;

  // The bank address carries no information for the init sequence.
  logic              unused_sink;
  assign unused_sink = ^{ba, mr_valid};

  assign is_nop    = (cmd == CMD_NOP);
  assign timer_inc = (timer_q == TMR_SAT) ? timer_q : timer_q + TMR_ONE;
  assign ref_inc   = (ref_seen_q == 4'hF) ? ref_seen_q : ref_seen_q + 4'd1;
  assign mr_valid  = mr_fields_ok(addr[MR_CL_MSB:MR_CL_LSB], addr[MR_BL_MSB:MR_BL_LSB])
                     && (addr[ADDR_W-1:MR_RSVD_LSB] == '0);

`ifdef SDRAM_MON_MODE_CHECK_EN
  assign lmr_accept = mr_valid;
`else
  assign lmr_accept = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    pwr_cnt_d   = pwr_cnt_q;
    timer_d     = timer_inc;
    init_done_d = init_done_q;
    init_err_d  = init_err_q;
    err_code_d  = err_code_q;
    mode_reg_d  = mode_reg_q;
    ref_seen_d  = ref_seen_q;
    raise       = ERR_NONE;

    // Timer semantics: loaded with 1 on the edge that accepts a command, so
    // in cycle N+k it reads k and a command is legal once timer_q >= T.
    // CKE is checked first in every branch: it outranks command errors.
    case (state_q)
      ST_PWR: begin
        if (!cke) begin
          raise = ERR_CKE;
        end else if (is_nop) begin
          if (pwr_cnt_q != PWR_DONE) pwr_cnt_d = pwr_cnt_q + 1'b1;
        end else if (pwr_cnt_q < PWR_DONE) begin
          raise = ERR_EARLY;
        end else if (cmd == CMD_PRE && addr[PRECHARGE_ALL_BIT]) begin
          state_d = ST_PRE;
          timer_d = TMR_ONE;
        end else begin
          raise = ERR_ORDER;
        end
      end

      ST_PRE: begin
        if (!cke) begin
          raise = ERR_CKE;
        end else if (!is_nop) begin
          if (timer_q < T_RP_C) begin
            raise = ERR_TIMING;
          end else if (cmd == CMD_REF) begin
            ref_seen_d = ref_inc;
            state_d    = ST_REF;
            timer_d    = TMR_ONE;
          end else begin
            raise = ERR_ORDER;
          end
        end
      end

      ST_REF: begin
        if (!cke) begin
          raise = ERR_CKE;
        end else if (!is_nop) begin
          if (timer_q < T_RFC_C) begin
            raise = ERR_TIMING;
          end else if (cmd == CMD_REF && ref_seen_q < REF_REQ) begin
            ref_seen_d = ref_inc;
            timer_d    = TMR_ONE;
          end else if (cmd == CMD_LMR && ref_seen_q == REF_REQ) begin
            // Captured even when the value is rejected, to aid debug.
            mode_reg_d = addr;
            if (lmr_accept) begin
              state_d = ST_MRD;
              timer_d = TMR_ONE;
            end else begin
              raise = ERR_MODE;
            end
          end else begin
            raise = ERR_ORDER;
          end
        end
      end

      ST_MRD: begin
        if (!cke) begin
          raise = ERR_CKE;
        end else if (!is_nop && timer_q < T_MRD_C) begin
          raise = ERR_TIMING;
        end else if (timer_inc >= T_MRD_C) begin
          // Done on the edge at which the timer reaches T_MRD.
          init_done_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE, ST_ERR: begin
        timer_d = timer_q;
      end

      default: begin
        state_d = ST_PWR;
      end
    endcase

    // Only non-error states can raise, so err_code keeps the first error.
    if (raise != ERR_NONE) begin
      state_d    = ST_ERR;
      init_err_d = 1'b1;
      err_code_d = raise;
    end
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      state_q     <= ST_PWR;
      pwr_cnt_q   <= '0;
      timer_q     <= '0;
      init_done_q <= 1'b0;
      init_err_q  <= 1'b0;
      err_code_q  <= ERR_NONE;
      mode_reg_q  <= '0;
      ref_seen_q  <= '0;
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      timer_q     <= timer_d;
      init_done_q <= init_done_d;
      init_err_q  <= init_err_d;
      err_code_q  <= err_code_d;
      mode_reg_q  <= mode_reg_d;
      ref_seen_q  <= ref_seen_d;
    end
  end

  assign init_done = init_done_q;
  assign init_err  = init_err_q;
  assign err_code  = err_code_q;
  assign mode_reg  = mode_reg_q;
  assign ref_seen  = ref_seen_q;

endmodule
